// File: rtl/spi_daisy_sched.sv
// Scheduler for a daisy chain of 8-bit SPI (mode 0) shift-register slaves: buffers one command per slave,
// runs one cs frame of N_SLAVES*8 bits and returns the captured bytes. Optional macro: DAISY_AUTO_START_EN.
module spi_daisy_sched #(
    parameter int N_SLAVES = 4,
    parameter int CLK_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [7:0] req_data,
    output logic       req_ready,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs
);
    localparam int NB = 8 * N_SLAVES;
    localparam int HW = $clog2(CLK_DIV);
    localparam int BW = $clog2(16 * N_SLAVES + 1);
    localparam int SW = $clog2(N_SLAVES + 1);
    localparam logic [HW-1:0] HP_LAST   = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_TGL  = BW'(16 * N_SLAVES - 1);
    localparam logic [SW-1:0] FULL      = SW'(N_SLAVES);
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_SLAVES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_UNLOAD} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hp_q, hp_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [SW-1:0] count_q, count_d;
    logic [NB-1:0] tx_q, tx_d;
    logic [NB-1:0] rx_q, rx_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          launch_s;
    logic          hp_end_s;
    logic [NB-1:0] rx_next_s;

`ifdef DAISY_AUTO_START_EN
    logic unused_start_s;
    assign unused_start_s = start;
    assign launch_s       = (count_q == FULL);
`else
    assign launch_s       = start && (count_q == FULL);
`endif

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        count_d     = count_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        done_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        hp_end_s    = (hp_q == HP_LAST);
        rx_next_s   = rx_q << 8;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    tx_d[NB - 8 - 8 * int'(count_q) +: 8] = req_data;
                    count_d = count_q + SW'(1);
                end else if (launch_s) begin
                    state_d = S_SETUP;
                    cs_d    = 1'b0;
                    mosi_d  = tx_q[NB-1];
                    hp_d    = '0;
                    bit_d   = '0;
                end else begin
                    count_d = count_q;
                end
            end
            S_SETUP: begin
                if (hp_end_s) begin
                    state_d = S_SHIFT;
                    hp_d    = '0;
                end else begin
                    hp_d    = hp_q + HW'(1);
                end
            end
            S_SHIFT: begin
                if (hp_end_s) begin
                    hp_d   = '0;
                    sclk_d = ~sclk_q;
                    bit_d  = bit_q + BW'(1);
                    // sclk_q low here means this toggle is a rising edge
                    if (!sclk_q) begin
                        rx_d = {rx_q[NB-2:0], miso};
                    end else if (bit_q == LAST_TGL) begin
                        state_d = S_HOLD;
                    end else begin
                        tx_d   = {tx_q[NB-2:0], 1'b0};
                        mosi_d = tx_q[NB-2];
                    end
                end else begin
                    hp_d = hp_q + HW'(1);
                end
            end
            S_HOLD: begin
                if (hp_end_s) begin
                    state_d     = S_UNLOAD;
                    cs_d        = 1'b1;
                    slot_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q[NB-1 -: 8];
                end else begin
                    hp_d = hp_q + HW'(1);
                end
            end
            S_UNLOAD: begin
                if (rsp_valid_q && rsp_ready && (slot_q == LAST_SLOT)) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    done_d      = 1'b1;
                    count_d     = '0;
                end else if (rsp_valid_q && rsp_ready) begin
                    slot_d     = slot_q + SW'(1);
                    rx_d       = rx_next_s;
                    rsp_data_d = rx_next_s[NB-1 -: 8];
                end else begin
                    rsp_data_d = rsp_data_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE) && (count_d < FULL);
    end

    // State and registered outputs; reset forces cs high and sclk low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hp_q        <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            count_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            count_q     <= count_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs        = cs_q;

endmodule
